// File: rtl/aux_req_encoder.sv
// aux_req_encoder
// Serializes one DisplayPort AUX request (native or I2C-over-AUX) into a
// byte stream: 3-byte header, optional LEN byte and optional write payload.
// Write payload is staged in an internal FIFO that may be filled before the
// descriptor arrives. The byte output stage is registered with ready/valid
// backpressure.

module aux_req_encoder #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_vld,
  output logic                         req_rdy,
  input  logic                         req_native,
  input  logic [1:0]                   req_cmd,
  input  logic                         req_mot,
  input  logic                         req_addr_only,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [7:0]                   req_len,
  input  logic [7:0]                   wdata,
  input  logic                         wdata_vld,
  output logic                         wdata_rdy,
  output logic [7:0]                   out_byte,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         out_last,
  output logic                         req_err,
  input  logic                         abort,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] fifo_level
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LVL_W = $clog2(MAX_LEN + 1);

  // Writes longer than this many bytes cannot be held in the FIFO.
  localparam logic [8:0] LEN_LIMIT = 9'(MAX_LEN);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_LEN     = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_WSU   = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // A descriptor is unusable if it is reserved, asks for an I2C-only
  // feature in native mode, or carries more payload than the FIFO holds.
  function automatic logic desc_invalid(
    input logic       native,
    input logic [1:0] cmd,
    input logic       addr_only,
    input logic [7:0] len
  );
    logic too_long;
    too_long = (cmd == CMD_WRITE) & ~addr_only & ({1'b0, len} >= LEN_LIMIT);
    desc_invalid = (cmd == CMD_RSVD)
                 | ((cmd == CMD_WSU) & native)
                 | (addr_only & native)
                 | too_long;
  endfunction

  // Header byte selected by position 0..2.
  function automatic logic [7:0] hdr_byte(
    input logic [1:0] idx,
    input logic       native,
    input logic       mot,
    input logic [1:0] cmd,
    input logic [3:0] addr_hi,
    input logic [7:0] addr_mid,
    input logic [7:0] addr_lo
  );
    case (idx)
      2'd0: begin
        if (native) begin
          hdr_byte = {1'b1, 1'b0, cmd, addr_hi};
        end else begin
          hdr_byte = {1'b0, mot, cmd, addr_hi};
        end
      end
      2'd1:    hdr_byte = addr_mid;
      2'd2:    hdr_byte = addr_lo;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  // FIFO pointer increment, wrapping modulo MAX_LEN.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_LEN - 1)) begin
      ptr_inc = PTR_W'(0);
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]        state_r;
  logic              native_r;
  logic              mot_r;
  logic              addr_only_r;
  logic [1:0]        cmd_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic [1:0]        hdr_idx_r;
  logic [7:0]        pay_cnt_r;

  logic [7:0]        out_byte_r;
  logic              out_vld_r;
  logic              out_last_r;
  logic              req_err_r;

  logic [7:0]        mem_r [0:MAX_LEN-1];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic       req_rdy_s;
  logic       accept_s;
  logic       reject_s;
  logic       load_en_s;
  logic       final_hold_s;
  logic       fifo_empty_s;
  logic       fifo_full_s;
  logic       push_s;
  logic       pop_s;
  logic       is_write_s;
  logic [7:0] rd_data_s;

  // Handshake qualifiers and FIFO push/pop decisions.
  always_comb begin
    req_rdy_s    = (state_r == ST_IDLE) & ~out_vld_r;
    accept_s     = req_vld & req_rdy_s & ~abort;
    reject_s     = desc_invalid(req_native, req_cmd, req_addr_only, req_len);
    load_en_s    = ~out_vld_r | out_rdy;
    // The final byte of a request sits in the stage until it is taken.
    final_hold_s = out_vld_r & out_last_r;
    fifo_empty_s = (level_r == LVL_W'(0));
    fifo_full_s  = (level_r == LVL_W'(MAX_LEN));
    push_s       = wdata_vld & ~fifo_full_s & ~abort;
    pop_s        = (state_r == ST_PAYLOAD) & ~final_hold_s & load_en_s
                 & ~fifo_empty_s & ~abort;
    is_write_s   = (cmd_r == CMD_WRITE);
    rd_data_s    = mem_r[rd_ptr_r];
  end

  // ---------------------------------------------------------------------
  // Request FSM and registered output stage
  // ---------------------------------------------------------------------

  // Sequence header, LEN and payload bytes into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      native_r    <= 1'b0;
      mot_r       <= 1'b0;
      addr_only_r <= 1'b0;
      cmd_r       <= 2'b00;
      addr_r      <= {ADDR_W{1'b0}};
      len_r       <= 8'h00;
      hdr_idx_r   <= 2'd0;
      pay_cnt_r   <= 8'd0;
      out_byte_r  <= 8'h00;
      out_vld_r   <= 1'b0;
      out_last_r  <= 1'b0;
      req_err_r   <= 1'b0;
    end else if (abort) begin
      state_r    <= ST_IDLE;
      hdr_idx_r  <= 2'd0;
      pay_cnt_r  <= 8'd0;
      out_vld_r  <= 1'b0;
      out_last_r <= 1'b0;
      req_err_r  <= 1'b0;
    end else begin
      req_err_r <= accept_s & reject_s;
      if (final_hold_s) begin
        if (out_rdy) begin
          out_vld_r  <= 1'b0;
          out_last_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s && !reject_s) begin
              native_r    <= req_native;
              mot_r       <= req_mot;
              addr_only_r <= req_addr_only;
              cmd_r       <= req_cmd;
              addr_r      <= req_addr;
              len_r       <= req_len;
              hdr_idx_r   <= 2'd0;
              pay_cnt_r   <= 8'd0;
              state_r     <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (load_en_s) begin
              out_byte_r <= hdr_byte(hdr_idx_r, native_r, mot_r, cmd_r,
                                     addr_r[19:16], addr_r[15:8], addr_r[7:0]);
              out_vld_r  <= 1'b1;
              out_last_r <= (hdr_idx_r == 2'd2) & addr_only_r;
              hdr_idx_r  <= hdr_idx_r + 2'd1;
              if ((hdr_idx_r == 2'd2) && !addr_only_r) begin
                state_r <= ST_LEN;
              end
            end
          end
          ST_LEN: begin
            if (load_en_s) begin
              out_byte_r <= len_r;
              out_vld_r  <= 1'b1;
              out_last_r <= ~is_write_s;
              if (is_write_s) begin
                state_r <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (load_en_s) begin
              if (!fifo_empty_s) begin
                out_byte_r <= rd_data_s;
                out_vld_r  <= 1'b1;
                out_last_r <= (pay_cnt_r == len_r);
                pay_cnt_r  <= pay_cnt_r + 8'd1;
              end else begin
                // Underrun: drop valid and wait for the next byte.
                out_vld_r  <= 1'b0;
                out_last_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Payload FIFO
  // ---------------------------------------------------------------------

  // Circular buffer with occupancy counter; abort empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (abort) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign req_rdy    = req_rdy_s;
  assign wdata_rdy  = ~fifo_full_s;
  assign out_byte   = out_byte_r;
  assign out_vld    = out_vld_r;
  assign out_last   = out_last_r;
  assign req_err    = req_err_r;
  assign busy       = (state_r != ST_IDLE);
  assign fifo_level = level_r;

endmodule

// File: tb/tb_aux_req_encoder.sv
// Testbench for aux_req_encoder: table of directed requests, hand-written
// stall/underrun/abort/reset sequences, and randomized requests checked
// against a byte-list reference model.

module tb_aux_req_encoder;

  localparam int MAX_LEN = 16;
  localparam int LVL_W   = $clog2(MAX_LEN + 1);

  typedef struct packed {
    bit        native;
    bit [1:0]  cmd;
    bit        mot;
    bit        ao;
    bit [19:0] addr;
    bit [7:0]  len;
  } desc_t;

  typedef struct {
    desc_t    d;
    bit       exp_err;
    int       exp_n;
    bit [7:0] b0;
    bit [7:0] b1;
    bit [7:0] b2;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_vld;
  logic             req_rdy;
  logic             req_native;
  logic [1:0]       req_cmd;
  logic             req_mot;
  logic             req_addr_only;
  logic [19:0]      req_addr;
  logic [7:0]       req_len;
  logic [7:0]       wdata;
  logic             wdata_vld;
  logic             wdata_rdy;
  logic [7:0]       out_byte;
  logic             out_vld;
  logic             out_rdy;
  logic             out_last;
  logic             req_err;
  logic             abort;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  always #5 clk = ~clk;

  aux_req_encoder #(.MAX_LEN(MAX_LEN), .ADDR_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_native(req_native),
    .req_cmd(req_cmd), .req_mot(req_mot), .req_addr_only(req_addr_only),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_vld(wdata_vld), .wdata_rdy(wdata_rdy),
    .out_byte(out_byte), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_last(out_last), .req_err(req_err), .abort(abort),
    .busy(busy), .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];   // {last, byte}
  logic [7:0] obs_q[$];
  logic [7:0] pay_in[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(input desc_t d);
    return (d.cmd == 2'd3) || (d.cmd == 2'd2 && d.native) || (d.ao && d.native) ||
           (d.cmd == 2'd0 && !d.ao && (int'(d.len) + 1 > MAX_LEN));
  endfunction

  function automatic bit model_has_pay(input desc_t d);
    return (d.cmd == 2'd0) && !d.ao;
  endfunction

  task automatic model_build(input desc_t d, input logic [7:0] pay[$]);
    logic [7:0] b[$];
    int v;
    v = (d.native ? 128 : (d.mot ? 64 : 0)) + int'(d.cmd) * 16 + int'(d.addr[19:16]);
    b.push_back(8'(v));
    b.push_back(d.addr[15:8]);
    b.push_back(d.addr[7:0]);
    if (!d.ao) begin
      b.push_back(d.len);
      if (model_has_pay(d)) begin
        foreach (pay[i]) b.push_back(pay[i]);
      end
    end
    exp_q.delete();
    for (int i = 0; i < b.size(); i++) exp_q.push_back({(i == b.size() - 1), b[i]});
  endtask

  task automatic drive_desc(input desc_t d);
    req_vld       = 1'b1;
    req_native    = d.native;
    req_cmd       = d.cmd;
    req_mot       = d.mot;
    req_addr_only = d.ao;
    req_addr      = d.addr;
    req_len       = d.len;
  endtask

  task automatic scramble_desc();
    req_vld       = 1'b0;
    req_native    = 1'($urandom_range(0, 1));
    req_cmd       = 2'($urandom_range(0, 3));
    req_mot       = 1'($urandom_range(0, 1));
    req_addr_only = 1'($urandom_range(0, 1));
    req_addr      = 20'($urandom);
    req_len       = 8'($urandom);
  endtask

  // One complete request: preload npre payload bytes, submit, stream the
  // rest every `pace` cycles, and check every accepted byte.
  task automatic run_txn(input desc_t d, input int npre, input int pace, input bit rand_rdy,
                         input bit chk_lat, output bit got_err, output int underruns);
    bit err;
    int total, pushed, k, guard;
    bit stall_prev, started;
    logic [8:0] e;
    logic [7:0] held_b;
    logic       held_l;
    logic [7:0] pay_all[$];
    logic [7:0] feed_q[$];
    err = model_err(d);
    got_err = 1'b0;
    underruns = 0;
    obs_q.delete();
    if (!err && model_has_pay(d)) begin
      if (pay_in.size() == int'(d.len) + 1) pay_all = pay_in;
      else for (int i = 0; i <= int'(d.len); i++) pay_all.push_back(8'($urandom_range(0, 255)));
    end
    pay_in.delete();
    model_build(d, pay_all);
    total  = exp_q.size();
    feed_q = pay_all;
    pushed = 0;
    guard  = 0;
    while (pushed < npre && feed_q.size() > 0 && guard < 64) begin
      @(negedge clk);
      guard++;
      wdata_vld = 1'b1;
      wdata = feed_q[0];
      if (wdata_rdy) begin
        void'(feed_q.pop_front());
        pushed++;
      end
    end
    @(negedge clk);
    wdata_vld = 1'b0;
    out_rdy = 1'b1;
    chk("pre_level", 32'(fifo_level), pushed);
    drive_desc(d);
    guard = 0;
    while (!req_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_rdy) begin
      chk("req_rdy_timeout", 32'(req_rdy), 32'd1);
      scramble_desc();
      return;
    end
    @(negedge clk);
    scramble_desc();
    got_err = req_err;
    chk("req_err_pulse", 32'(req_err), 32'(err));
    if (err) begin
      for (int j = 0; j < 3; j++) begin
        chk("rej_no_vld", 32'(out_vld), 32'd0);
        chk("rej_busy", 32'(busy), 32'd0);
        if (j > 0) chk("rej_err_one_cycle", 32'(req_err), 32'd0);
        @(negedge clk);
      end
      return;
    end
    k = 0;
    stall_prev = 1'b0;
    started = 1'b0;
    while (exp_q.size() > 0 && k < 400) begin
      if (feed_q.size() > 0 && (k % pace) == 0) begin
        wdata_vld = 1'b1;
        wdata = feed_q[0];
        if (wdata_rdy) void'(feed_q.pop_front());
      end else begin
        wdata_vld = 1'b0;
      end
      if (stall_prev) begin
        chk("hold_vld", 32'(out_vld), 32'd1);
        chk("hold_byte", 32'(out_byte), 32'(held_b));
        chk("hold_last", 32'(out_last), 32'(held_l));
      end
      out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_prev = 1'b0;
      if (out_vld) begin
        started = 1'b1;
        if (out_rdy) begin
          e = exp_q.pop_front();
          obs_q.push_back(out_byte);
          chk("byte", 32'(out_byte), 32'(e[7:0]));
          chk("last", 32'(out_last), 32'(e[8]));
          if (chk_lat && exp_q.size() == 0) chk("latency", k, total);
        end else begin
          stall_prev = 1'b1;
          held_b = out_byte;
          held_l = out_last;
        end
      end else if (started) begin
        underruns++;
      end
      @(negedge clk);
      k++;
    end
    wdata_vld = 1'b0;
    out_rdy = 1'b1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: %0d bytes still outstanding, required 0", exp_q.size());
    end
    chk("end_vld", 32'(out_vld), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_req_rdy", 32'(req_rdy), 32'd1);
    chk("end_level", 32'(fifo_level), 32'd0);
  endtask

  function automatic vec_t mk(input bit native, input bit [1:0] cmd, input bit mot, input bit ao,
                              input bit [19:0] addr, input bit [7:0] len, input bit err,
                              input int n, input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
    vec_t v;
    v.d.native = native; v.d.cmd = cmd; v.d.mot = mot; v.d.ao = ao;
    v.d.addr = addr; v.d.len = len;
    v.exp_err = err; v.exp_n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tab[11];
    desc_t d;
    bit    ge;
    int    ur, cnt, guard;

    tab[0]  = mk(1, 2'd1, 0, 0, 20'h12345, 8'h0F, 0, 4,  8'h91, 8'h23, 8'h45);
    tab[1]  = mk(0, 2'd0, 1, 0, 20'h00050, 8'h01, 0, 6,  8'h40, 8'h00, 8'h50);
    tab[2]  = mk(0, 2'd1, 0, 1, 20'h00050, 8'h00, 0, 3,  8'h10, 8'h00, 8'h50);
    tab[3]  = mk(1, 2'd0, 0, 0, 20'hABCDE, 8'h0F, 0, 20, 8'h8A, 8'hBC, 8'hDE);
    tab[4]  = mk(1, 2'd0, 0, 0, 20'h00100, 8'h10, 1, 0,  8'h00, 8'h00, 8'h00);
    tab[5]  = mk(1, 2'd1, 0, 1, 20'h00050, 8'h00, 1, 0,  8'h00, 8'h00, 8'h00);
    tab[6]  = mk(0, 2'd3, 0, 0, 20'h00050, 8'h00, 1, 0,  8'h00, 8'h00, 8'h00);
    tab[7]  = mk(1, 2'd2, 0, 0, 20'h00050, 8'h00, 1, 0,  8'h00, 8'h00, 8'h00);
    tab[8]  = mk(0, 2'd2, 1, 0, 20'h00050, 8'h00, 0, 4,  8'h60, 8'h00, 8'h50);
    tab[9]  = mk(0, 2'd0, 1, 1, 20'h00050, 8'h05, 0, 3,  8'h40, 8'h00, 8'h50);
    tab[10] = mk(1, 2'd0, 0, 0, 20'h00001, 8'h00, 0, 5,  8'h80, 8'h00, 8'h01);

    rst_n = 1'b0;
    abort = 1'b0;
    out_rdy = 1'b1;
    wdata = 8'h00;
    wdata_vld = 1'b0;
    scramble_desc();

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_byte", 32'(out_byte), 32'h00);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_req_err", 32'(req_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_wdata_rdy", 32'(wdata_rdy), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, out_rdy held high, payload fully pre-loaded.
    for (int i = 0; i < 11; i++) begin
      if (i == 1) begin
        pay_in.delete();
        pay_in.push_back(8'hAA);
        pay_in.push_back(8'hBB);
      end
      run_txn(tab[i].d, 99, 1, 1'b0, 1'b1, ge, ur);
      chk("tab_err", 32'(ge), 32'(tab[i].exp_err));
      chk("tab_count", obs_q.size(), tab[i].exp_n);
      if (!tab[i].exp_err && obs_q.size() >= 3) begin
        chk("tab_b0", 32'(obs_q[0]), 32'(tab[i].b0));
        chk("tab_b1", 32'(obs_q[1]), 32'(tab[i].b1));
        chk("tab_b2", 32'(obs_q[2]), 32'(tab[i].b2));
      end
      if (i == 1 && obs_q.size() == 6) begin
        chk("tab_pay0", 32'(obs_q[4]), 32'hAA);
        chk("tab_pay1", 32'(obs_q[5]), 32'hBB);
      end
    end

    // Slow payload: deterministic underrun, then random backpressure.
    d = '{native: 1'b0, cmd: 2'd0, mot: 1'b0, ao: 1'b0, addr: 20'h00123, len: 8'h03};
    run_txn(d, 0, 3, 1'b0, 1'b0, ge, ur);
    chk("underrun_seen", 32'(ur > 0), 32'd1);
    run_txn(d, 0, 3, 1'b1, 1'b0, ge, ur);

    // Abort after payload byte 2 of 8, with a coincident push.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wdata_vld = 1'b1;
      wdata = 8'(i + 1);
    end
    @(negedge clk);
    wdata_vld = 1'b0;
    d = '{native: 1'b1, cmd: 2'd0, mot: 1'b0, ao: 1'b0, addr: 20'h00100, len: 8'h07};
    drive_desc(d);
    out_rdy = 1'b1;
    @(negedge clk);
    scramble_desc();
    cnt = 0;
    guard = 0;
    while (cnt < 7 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (out_vld) cnt++;
    end
    chk("abort_reach", cnt, 7);
    @(negedge clk);
    abort = 1'b1;
    wdata_vld = 1'b1;
    wdata = 8'h55;
    @(negedge clk);
    abort = 1'b0;
    wdata_vld = 1'b0;
    chk("abort_vld", 32'(out_vld), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    chk("abort_level", 32'(fifo_level), 32'd0);
    chk("abort_req_rdy", 32'(req_rdy), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    d = '{native: 1'b1, cmd: 2'd1, mot: 1'b0, ao: 1'b0, addr: 20'h0ABCD, len: 8'h03};
    run_txn(d, 0, 1, 1'b0, 1'b1, ge, ur);
    chk("post_abort_b0", 32'(obs_q.size() > 0 ? obs_q[0] : 8'h00), 32'h90);
    d = '{native: 1'b1, cmd: 2'd0, mot: 1'b0, ao: 1'b0, addr: 20'h00200, len: 8'h01};
    run_txn(d, 2, 1, 1'b0, 1'b1, ge, ur);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    wdata_vld = 1'b1;
    wdata = 8'h77;
    @(negedge clk);
    wdata_vld = 1'b0;
    d = '{native: 1'b1, cmd: 2'd1, mot: 1'b0, ao: 1'b0, addr: 20'h12345, len: 8'h02};
    drive_desc(d);
    @(negedge clk);
    scramble_desc();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_vld", 32'(out_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_vld), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_req_rdy", 32'(req_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized requests against the model.
    for (int n = 0; n < 40; n++) begin
      d.native = 1'($urandom_range(0, 1));
      d.cmd    = 2'($urandom_range(0, 3));
      d.mot    = 1'($urandom_range(0, 1));
      d.ao     = ($urandom_range(0, 4) == 0);
      d.addr   = 20'($urandom);
      d.len    = (d.cmd == 2'd0) ? 8'($urandom_range(0, MAX_LEN)) : 8'($urandom);
      run_txn(d, $urandom_range(0, 17), $urandom_range(1, 3), 1'b1, 1'b0, ge, ur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aux_req_encoder.md
# aux_req_encoder

- Parametrised DisplayPort AUX request serializer.
- Accepts one request descriptor per transaction, in either mode:
  - native AUX
  - I2C-over-AUX, including address-only start/stop transactions
- Emits the request header and optional write payload as a byte stream with ready/valid backpressure.
- Sits between the AUX transaction de-mux and the AUX Manchester/PHY transmit path.
- Buffers write payload in an internal FIFO of depth MAX_LEN.

## Interface
- MAX_LEN, 16: payload FIFO depth and maximum bytes per request (power of two, 1..16).
- ADDR_W, 20: request address width (fixed at 20 for DP; other values unsupported).
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- req_vld  in  1  request descriptor valid.
- req_rdy  out  1  encoder idle and able to accept a descriptor.
- req_native  in  1  1 = native AUX, 0 = I2C-over-AUX.
- req_cmd  in  2  00 write, 01 read, 10 write-status-update (I2C only), 11 reserved.
- req_mot  in  1  I2C middle-of-transaction bit; ignored when req_native=1.
- req_addr_only  in  1  3-byte header only, no LEN byte, no payload (I2C only).
- req_addr  in  ADDR_W  AUX/I2C address.
- req_len  in  8  transfer length minus one (DP encoding).
- wdata  in  8  write payload byte.
- wdata_vld  in  1  payload byte valid.
- wdata_rdy  out  1  FIFO not full.
- out_byte  out  8  serialized byte.
- out_vld  out  1  out_byte valid.
- out_rdy  in  1  downstream accepts out_byte.
- out_last  out  1  marks final byte of the request.
- req_err  out  1  one-cycle pulse when a descriptor is rejected.
- abort  in  1  synchronous abort: flush and return to idle.
- busy  out  1  FSM not in IDLE.
- fifo_level  out  $clog2(MAX_LEN+1)  current FIFO occupancy.

## Operation
- **Header byte 0**
  - Native: {1, 0, req_cmd, req_addr[19:16]}.
  - I2C: {0, req_mot, req_cmd, req_addr[19:16]}.
- **Header bytes 1 and 2:** req_addr[15:8], then req_addr[7:0].
- **Byte 3 (LEN):** req_len; omitted when req_addr_only=1.
- **Payload:** when req_cmd=00 and req_addr_only=0, exactly req_len+1 bytes are popped from the FIFO in arrival order.
- **Descriptor capture:** all descriptor fields are registered on acceptance (req_vld & req_rdy). Later changes to the inputs have no effect.
- **Rejection:** a descriptor is rejected if any of the following holds:
  - req_len+1 > MAX_LEN on a write;
  - req_addr_only=1 with req_native=1;
  - req_cmd=11;
  - req_cmd=10 with req_native=1.

  On rejection, req_err pulses the next cycle, no bytes are emitted and the FSM stays in IDLE.
- **FSM states:**
  - IDLE: wait for accepted descriptor.
  - HDR: bytes 0..2.
  - LEN: byte 3.
  - PAYLOAD: write data bytes.
  - IDLE is re-entered when the last byte is accepted.
- **FSM transitions:**
  - IDLE→HDR on a valid, accepted descriptor.
  - HDR→IDLE after byte 2 when addr_only=1.
  - HDR→LEN otherwise.
  - LEN→PAYLOAD for writes.
  - LEN→IDLE for reads.
  - PAYLOAD→IDLE after payload byte req_len.
- **FIFO:**
  - Pushes on wdata_vld & wdata_rdy, independent of FSM state; payload may be pre-loaded before the descriptor.
  - No bypass: a byte pushed in cycle t is poppable at t+1.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - Pointers wrap modulo MAX_LEN.
- **Underrun:** in PAYLOAD with the FIFO empty, out_vld deasserts, the state holds, and output resumes when data arrives.
- **abort:** has priority over all other events.
  - Next cycle: out_vld=0, out_last=0, FSM=IDLE, FIFO empty, level 0.
  - A push coincident with abort is discarded.
- **out_last:** high with the final byte only. The final byte is byte 2 (addr-only), byte 3 (read), or the last payload byte (write).

## Timing
- **Reset values:** out_byte 0x00, out_vld 0, out_last 0, req_err 0, busy 0, fifo_level 0, req_rdy 1, wdata_rdy 1, FSM IDLE.
- **req_rdy** equals (state==IDLE) & !out_vld, so back-to-back requests have one idle cycle between them.
- **Output stage:** out_byte, out_vld and out_last are registered.
  - The stage loads when !out_vld | out_rdy, giving 1 byte/cycle with out_rdy held high.
- **Hold rule:** while out_vld=1 and out_rdy=0, out_byte and out_last stay stable.
- **Latency:** descriptor accepted at edge t → byte 0 valid after edge t+1.
- **Read, no stall:** last byte is valid at t+4.
- **Write, no stall, FIFO pre-filled:** final payload byte is valid at t+4+req_len+1.
- **Reset mid-transaction:** outputs clear immediately, asynchronously; the partial request is discarded.

## Test plan
- Native read, addr 0x12345, len 0x0F, out_rdy=1 → 0x91, 0x23, 0x45, 0x0F on consecutive cycles, out_last on 0x0F, busy drops after.
- I2C write, MOT=1, addr 0x00050, len 0x01, payload pre-loaded 0xAA, 0xBB → 0x40, 0x00, 0x50, 0x01, 0xAA, 0xBB, out_last on 0xBB, fifo_level 2→0.
- I2C address-only read, MOT=0, addr 0x00050 → 0x10, 0x00, 0x50, out_last on 0x50, no LEN byte.
- Write len 0x03 with payload arriving one byte per 3 cycles, plus out_rdy toggled randomly → no byte lost or duplicated; out_byte stable while stalled; out_vld low during underrun.
- MAX_LEN=16: write with len 0x10 → req_err one cycle, no out_vld. Native with addr_only=1 → req_err.
- abort asserted after payload byte 2 of 8 → next cycle out_vld=0, fifo_level=0, req_rdy=1. A following native read is then encoded correctly.
